// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates two requesters onto one synchronous memory port
// Every access is address phase (ACCESS) then data phase (RESP), then a registered ack.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic elig0, elig1, win, starved;

  // A port whose ack is high this cycle still shows the old req; keep it out of arbitration.
  assign elig0 = req0_i & ~ack0_q;
  assign elig1 = req1_i & ~ack1_q;

  always_comb begin
    win     = 1'b0;
    starved = 1'b0;
    if (RR_MODE != 0) begin
      win = (elig0 && elig1) ? ~last_grant_q : elig1;
    end else begin
      starved = (STARVE_LIMIT != 0) && (starve_cnt_q == CNT_MAX);
      win     = ~elig0 | (starved & elig1);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    starve_cnt_d = starve_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        mem_we_d = 1'b0;
        if (elig0 || elig1) begin
          grant_d      = win;
          last_grant_d = win;
          write_d      = win ? we1_i : we0_i;
          mem_addr_d   = win ? addr1_i : addr0_i;
          mem_wdata_d  = win ? wdata1_i : wdata0_i;
          mem_we_d     = win ? we1_i : we0_i;
          state_d      = ACCESS;
          if (win || !req1_i) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
      end
      ACCESS: begin
        mem_we_d = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (!write_q) begin
          if (grant_q) rdata1_d = mem_rdata_i;
          else         rdata0_d = mem_rdata_i;
        end
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      starve_cnt_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter (fixed-priority and round-robin)
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_req0, a_we0, a_req1, a_we1, a_ack0, a_ack1, a_mem_we;
  logic [AW-1:0] a_addr0, a_addr1, a_mem_addr;
  logic [DW-1:0] a_wdata0, a_wdata1, a_rdata0, a_rdata1, a_mem_wdata, a_mem_rdata;
  logic          b_reset, b_req0, b_we0, b_req1, b_we1, b_ack0, b_ack1, b_mem_we;
  logic [AW-1:0] b_addr0, b_addr1, b_mem_addr;
  logic [DW-1:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .STARVE_LIMIT(4)) u_fixed (
    .clk_i(clk), .reset_i(a_reset),
    .req0_i(a_req0), .we0_i(a_we0), .addr0_i(a_addr0), .wdata0_i(a_wdata0),
    .ack0_o(a_ack0), .rdata0_o(a_rdata0),
    .req1_i(a_req1), .we1_i(a_we1), .addr1_i(a_addr1), .wdata1_i(a_wdata1),
    .ack1_o(a_ack1), .rdata1_o(a_rdata1),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_we_o(a_mem_we),
    .mem_rdata_i(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
    .clk_i(clk), .reset_i(b_reset),
    .req0_i(b_req0), .we0_i(b_we0), .addr0_i(b_addr0), .wdata0_i(b_wdata0),
    .ack0_o(b_ack0), .rdata0_o(b_rdata0),
    .req1_i(b_req1), .we1_i(b_we1), .addr1_i(b_addr1), .wdata1_i(b_wdata1),
    .ack1_o(b_ack1), .rdata1_o(b_rdata1),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_we_o(b_mem_we),
    .mem_rdata_i(b_mem_rdata)
  );

  // Synchronous memories with a preload side door
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic          pa_we, pb_we;
  logic [AW-1:0] pa_addr, pb_addr;
  logic [DW-1:0] pa_data, pb_data;

  always @(posedge clk) begin
    if (pa_we) mem_a[pa_addr] <= pa_data;
    else if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= mem_a[a_mem_addr];
  end

  always @(posedge clk) begin
    if (pb_we) mem_b[pb_addr] <= pb_data;
    else if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= mem_b[b_mem_addr];
  end

  int ackq_a[$];
  int ackq_b[$];
  int we_cnt_a = 0;
  int both_a   = 0;
  int both_b   = 0;

  always @(negedge clk) begin
    if (a_ack0) ackq_a.push_back(0);
    if (a_ack1) ackq_a.push_back(1);
    if (b_ack0) ackq_b.push_back(0);
    if (b_ack1) ackq_b.push_back(1);
    if (a_mem_we) we_cnt_a++;
    if (a_ack0 && a_ack1) both_a++;
    if (b_ack0 && b_ack1) both_b++;
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    pa_we = 1'b1; pa_addr = addr; pa_data = data;
    tick(1);
    pa_we = 1'b0;
  endtask

  task automatic preload_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    pb_we = 1'b1; pb_addr = addr; pb_data = data;
    tick(1);
    pb_we = 1'b0;
  endtask

  initial begin
    int            q0;
    int            we_base;
    logic [7:0]    ack_vec;
    logic [5:0]    exp_order;

    a_reset = 1'b1; b_reset = 1'b1;
    pa_we = 1'b0; pa_addr = '0; pa_data = '0;
    pb_we = 1'b0; pb_addr = '0; pb_data = '0;
    a_req0 = 1'b0; a_we0 = 1'b0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 1'b0; a_we1 = 1'b0; a_addr1 = '0; a_wdata1 = '0;
    // B waits in reset with both requests already up
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 10'h020; b_wdata0 = '0;
    b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 10'h021; b_wdata1 = '0;
    tick(3);

    chk("rst_a_ctrl", 32'({a_ack0, a_ack1, a_mem_we, a_mem_addr, a_mem_wdata}), 32'h0);
    chk("rst_a_rdata", {a_rdata0, a_rdata1}, 32'h0);
    chk("rst_b_ctrl", 32'({b_ack0, b_ack1, b_mem_we, b_mem_addr, b_mem_wdata}), 32'h0);
    chk("rst_b_rdata", {b_rdata0, b_rdata1}, 32'h0);

    preload_a(10'h012, 16'hBEEF);
    preload_b(10'h020, 16'h0A0A);
    preload_b(10'h021, 16'h1B1B);
    a_reset = 1'b0;
    tick(1);

    // Single read on port 1
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 10'h012;
    tick(1);
    chk("t1_mem_addr", 32'(a_mem_addr), 32'h012);
    chk("t1_mem_we", 32'(a_mem_we), 32'h0);
    tick(1);
    chk("t1_ack_early", 32'(a_ack1), 32'h0);
    a_req1 = 1'b0;
    tick(1);
    chk("t1_ack1", 32'(a_ack1), 32'h1);
    chk("t1_rdata1", 32'(a_rdata1), 32'hBEEF);
    tick(1);
    chk("t1_ack_pulse", 32'(a_ack1), 32'h0);
    chk("t1_rdata_hold", 32'(a_rdata1), 32'hBEEF);

    // Stale-req mask: req held with unchanged address across the ack
    a_req1 = 1'b1;
    ack_vec = '0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      ack_vec[k-1] = a_ack1;
      if (k == 8) a_req1 = 1'b0;
    end
    chk("t5_ack_pattern", 32'(ack_vec), 32'h44);
    tick(2);
    chk("t5_rdata1", 32'(a_rdata1), 32'hBEEF);

    // Reset while in RESP: no ack, rdata cleared
    q0 = ackq_a.size();
    a_req1 = 1'b1;
    tick(2);
    a_reset = 1'b1; a_req1 = 1'b0;
    tick(1);
    chk("rresp_ack1", 32'(a_ack1), 32'h0);
    chk("rresp_rdata1", 32'(a_rdata1), 32'h0);
    a_reset = 1'b0;
    tick(4);
    chk("rresp_no_ack", 32'(ackq_a.size() - q0), 32'h0);

    // Write then read on port 0
    we_base = we_cnt_a;
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 10'h3FF; a_wdata0 = 16'h1234;
    tick(1);
    chk("t2_wr_phase", 32'({a_mem_we, a_mem_addr, a_mem_wdata}), {5'd0, 1'b1, 10'h3FF, 16'h1234});
    tick(1);
    chk("t2_we_drop", 32'(a_mem_we), 32'h0);
    tick(1);
    chk("t2_wr_ack0", 32'(a_ack0), 32'h1);
    tick(1);
    chk("t2_ack_pulse", 32'(a_ack0), 32'h0);
    a_we0 = 1'b0;
    tick(3);
    chk("t2_rd_ack0", 32'(a_ack0), 32'h1);
    chk("t2_rdata0", 32'(a_rdata0), 32'h1234);
    a_req0 = 1'b0;
    tick(2);
    chk("t2_we_cycles", 32'(we_cnt_a - we_base), 32'h1);
    chk("t2_mem_3ff", 32'(mem_a[10'h3FF]), 32'h1234);

    // Fixed priority with starvation guard; req1 dips on each port-0 ack cycle
    q0 = ackq_a.size();
    a_addr0 = 10'h100; a_we0 = 1'b0;
    a_addr1 = 10'h200; a_we1 = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        a_req0 = 1'b1;
        a_req1 = !(c == 3 || c == 7 || c == 11 || c == 15);
      end else begin
        a_req0 = 1'b0;
        a_req1 = 1'b0;
      end
      tick(1);
    end
    tick(3);
    exp_order = 6'b010000;
    chk("t3_n_acks", 32'(ackq_a.size() - q0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (ackq_a.size() > q0 + i)
        chk($sformatf("t3_grant%0d", i), 32'(ackq_a[q0+i]), 32'(exp_order[i]));
    end

    // Reset during ACCESS of a write
    q0 = ackq_a.size();
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 10'h005; a_wdata0 = 16'hAAAA;
    tick(1);
    chk("t6_access", 32'({a_mem_we, a_mem_addr}), {21'd0, 1'b1, 10'h005});
    a_reset = 1'b1; a_req0 = 1'b0;
    tick(1);
    chk("t6_rst_ctrl", 32'({a_ack0, a_ack1, a_mem_we, a_mem_addr, a_mem_wdata}), 32'h0);
    chk("t6_rst_rdata", {a_rdata0, a_rdata1}, 32'h0);
    chk("t6_mem_005", 32'(mem_a[10'h005]), 32'hAAAA);
    a_reset = 1'b0;
    tick(4);
    chk("t6_no_ack", 32'(ackq_a.size() - q0), 32'h0);
    chk("t6_idle_we", 32'(a_mem_we), 32'h0);

    // Round-robin: both requests held from reset release
    q0 = ackq_b.size();
    b_reset = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c == 10) begin
        b_req0 = 1'b0;
        b_req1 = 1'b0;
      end
      tick(1);
    end
    tick(3);
    exp_order = 6'b001010;
    chk("t4_n_acks", 32'(ackq_b.size() - q0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (ackq_b.size() > q0 + i)
        chk($sformatf("t4_grant%0d", i), 32'(ackq_b[q0+i]), 32'(exp_order[i]));
    end
    chk("t4_rdata0", 32'(b_rdata0), 32'h0A0A);
    chk("t4_rdata1", 32'(b_rdata1), 32'h1B1B);

    // Round-robin: only port 1 requesting
    q0 = ackq_b.size();
    b_req1 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) b_req1 = 1'b0;
      tick(1);
    end
    tick(3);
    chk("t4_solo_n", 32'(ackq_b.size() - q0), 32'd2);
    if (ackq_b.size() >= q0 + 2)
      chk("t4_solo_ports", 32'(ackq_b[q0] + ackq_b[q0+1]), 32'd2);

    // Round-robin: after a port-0 grant, a fresh tie goes to port 1
    b_req0 = 1'b1;
    tick(3);
    chk("t4_p0_ack", 32'(b_ack0), 32'h1);
    b_req0 = 1'b0;
    tick(2);
    q0 = ackq_b.size();
    b_req0 = 1'b1; b_req1 = 1'b1;
    tick(1);
    b_req0 = 1'b0; b_req1 = 1'b0;
    tick(5);
    chk("t4_tie_n", 32'(ackq_b.size() - q0), 32'd1);
    if (ackq_b.size() > q0)
      chk("t4_tie_port", 32'(ackq_b[q0]), 32'd1);

    chk("acks_exclusive_a", 32'(both_a), 32'h0);
    chk("acks_exclusive_b", 32'(both_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
